conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter WIDTH, default 8, signed pixel width in bits.
REQ-002 Parameter IMG_W, default 28, image width in pixels.
REQ-003 Parameter IMG_H, default 28, image height in pixels.
REQ-004 Parameter K, default 5, square kernel size; legal range is 2 <= K <= min(IMG_W, IMG_H).
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port global_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port i_clear, input, 1 bit: synchronous clear of the whole block, active-high.
REQ-008 Port i_valid, input, 1 bit: the pixel on i_data is accepted this cycle; there is no back-pressure.
REQ-009 Port i_data, input, WIDTH bits signed: pixel stream in row-major order.
REQ-010 Port o_window, output, K*K*WIDTH bits: window element (r,c) occupies bits [(r*K+c)*WIDTH +: WIDTH]; r=0 is the oldest row and c=0 is the oldest column.
REQ-011 Port o_valid, output, 1 bit: o_window holds a complete, valid KxK window.
REQ-012 Port o_frame_done, output, 1 bit: one-cycle pulse marking the last window of a frame.
REQ-013 Port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1).
- Both advance only on an accepted pixel.
- col wraps to 0 after IMG_W-1 and row then increments.
- After pixel (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-015 The block SHALL hold K-1 line buffers, each IMG_W deep, chained in series.
- LB0 input is i_data; LBj input is the output of LBj-1.
- Every line buffer shifts only on an accepted pixel.
REQ-016 The window array SHALL shift left by one column on each accepted pixel.
- Row K-1, column K-1 loads i_data.
- Row K-2-j, column K-1 loads the output of LBj.
REQ-017 On acceptance of pixel (row,col), window element (r,c) SHALL become the pixel at (row-(K-1-r), col-(K-1-c)).
REQ-018 o_valid SHALL be registered: high in the cycle after an accepted pixel with row>=K-1 and col>=K-1, and low otherwise.
- Latency from acceptance to o_valid is exactly 1 cycle.
REQ-019 o_window SHALL be driven directly from the window array and SHALL be held unchanged while no pixel is accepted.
REQ-020 The block SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1) o_valid pulses per frame, independent of gaps in i_valid.
REQ-021 o_frame_done SHALL go high in the same cycle as the o_valid that follows acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-022 The state machine SHALL have three states: IDLE, FILL, STREAM.
- IDLE to FILL on the first accepted pixel of a frame.
- FILL to STREAM on acceptance of pixel (K-2, IMG_W-1), i.e. the state is STREAM while row>=K-1.
- STREAM to IDLE on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-023 Back-to-back frames SHALL need no idle cycle.
- A pixel accepted in the cycle after the last pixel of a frame is pixel (0,0) of the next frame.
- Line buffers are not cleared between frames; stale data is never emitted in a window.
REQ-024 i_clear SHALL take priority over i_valid in the same cycle.
- On the next edge: counters = 0, line buffers = 0, window = 0, o_valid = 0, o_frame_done = 0, state = IDLE.
- The pixel presented in that cycle is discarded.
REQ-025 A cycle with i_valid=0 SHALL change no state and SHALL drive o_valid=0 and o_frame_done=0 in the following cycle.

Reset
REQ-026 While global_rst_n=0 the block SHALL asynchronously force:
- all counters, line buffers and window registers to 0;
- o_valid=0, o_frame_done=0, o_busy=0;
- state = IDLE.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first accepted pixel after release is pixel (0,0).

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE, FILL, STREAM) and the window-index helper used for the o_window bit slicing.
REQ-029 Each line buffer SHALL be one instance of the existing parameterised signed shift-register sub-module variable_shift_reg, with SIZE=IMG_W.
- Its ce is tied to accept; its rst is tied to i_clear.
REQ-030 Counters SHALL use $clog2(IMG_W) and $clog2(IMG_H) bits.

Verification
REQ-031 Defaults, 784 consecutive pixels with value = index mod 256:
- First o_valid comes 1 cycle after index 116 is accepted, with window (0,0)=0 and (4,4)=116.
- 576 o_valid pulses in total; o_frame_done coincides with the last one, which has (4,4)=783 mod 256.
REQ-032 Same frame with i_valid randomly deasserted about 40% of the time:
- The same 576 windows appear in the same order.
- o_window is stable in every gap.
REQ-033 Two frames back-to-back with no gap:
- Second frame windows match the reference model.
- No window mixes pixels from the two frames.
- Exactly two o_frame_done pulses.
REQ-034 global_rst_n pulsed low after pixel 300, then a full frame is sent:
- Outputs are zero during reset.
- 576 correct windows follow the release.
REQ-035 i_clear and i_valid asserted together at pixel 500:
- That pixel is dropped, o_valid=0 on the next cycle, state returns to IDLE.
- The following frame is correct.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared types and helpers for the sliding KxK convolution window generator.
package conv_window_gen_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StStream = 2'd2
  } state_e;

  // Flat element index of window position (r,c) inside the packed o_window bus.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/variable_shift_reg.sv
// Signed shift register of SIZE words; output is the word shifted in SIZE enables ago.
module variable_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] data_i,
  output logic signed [WIDTH-1:0] data_o
);

  logic signed [WIDTH-1:0] sr_q [SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SIZE); i++) sr_q[i] <= '0;
    end else if (rst) begin
      for (int i = 0; i < int'(SIZE); i++) sr_q[i] <= '0;
    end else if (ce) begin
      sr_q[0] <= data_i;
      for (int i = 1; i < int'(SIZE); i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign data_o = sr_q[SIZE-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streams a row-major image and presents every complete KxK neighbourhood as a packed window.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned K     = 5
) (
  input  logic                      clk,
  input  logic                      global_rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic signed [WIDTH-1:0]   i_data,
  output logic [K*K*WIDTH-1:0]      o_window,
  output logic                      o_valid,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  logic                    accept;
  logic                    col_last, row_last, in_window;
  logic [ColW-1:0]         col_q, col_d;
  logic [RowW-1:0]         row_q, row_d;
  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] win_q [K][K];
  logic signed [WIDTH-1:0] win_d [K][K];
  logic signed [WIDTH-1:0] lb_out [K-1];

  // A clear in the same cycle discards the presented pixel.
  assign accept    = i_valid & ~i_clear;
  assign col_last  = (col_q == ColW'(IMG_W - 1));
  assign row_last  = (row_q == RowW'(IMG_H - 1));
  assign in_window = (row_q >= RowW'(K - 1)) && (col_q >= ColW'(K - 1));

  for (genvar j = 0; j < int'(K) - 1; j++) begin : g_lb
    logic signed [WIDTH-1:0] lb_in;
    if (j == 0) begin : g_first
      assign lb_in = i_data;
    end else begin : g_chain
      assign lb_in = lb_out[j-1];
    end
    variable_shift_reg #(
      .WIDTH (WIDTH),
      .SIZE  (IMG_W)
    ) u_lb (
      .clk    (clk),
      .rst_n  (global_rst_n),
      .ce     (accept),
      .rst    (i_clear),
      .data_i (lb_in),
      .data_o (lb_out[j])
    );
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    win_d   = win_q;

    if (accept) begin
      valid_d = in_window;
      done_d  = row_last && col_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end

      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) win_d[r][c] = win_q[r][c+1];
      end
      win_d[K-1][K-1] = i_data;
      // Line buffer j delays by j+1 rows, feeding progressively older window rows.
      for (int j = 0; j < int'(K) - 1; j++) win_d[int'(K)-2-j][K-1] = lb_out[j];
    end

    unique case (state_q)
      StIdle:   if (accept) state_d = StFill;
      StFill:   if (accept && col_last && (row_q == RowW'(K - 2))) state_d = StStream;
      StStream: if (accept && col_last && row_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (i_clear) begin
      col_d   = '0;
      row_d   = '0;
      state_d = StIdle;
      valid_d = 1'b0;
      done_d  = 1'b0;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) win_d[r][c] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= StIdle;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) win_q[r][c] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  for (genvar r = 0; r < int'(K); r++) begin : g_row
    for (genvar c = 0; c < int'(K); c++) begin : g_col
      assign o_window[win_idx(r, c, K)*WIDTH +: WIDTH] = win_q[r][c];
    end
  end

  assign o_valid      = valid_q;
  assign o_frame_done = done_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen at default parameters, checked against a coordinate model.
module tb_conv_window_gen;

  localparam int W    = 8;
  localparam int IW   = 28;
  localparam int IH   = 28;
  localparam int KK   = 5;
  localparam int NPIX = IW * IH;
  localparam int WB   = KK * KK * W;
  localparam int NWIN = (IH - KK + 1) * (IW - KK + 1);

  logic                clk = 1'b0;
  logic                global_rst_n = 1'b0;
  logic                i_clear = 1'b0;
  logic                i_valid = 1'b0;
  logic signed [W-1:0] i_data = '0;
  logic [WB-1:0]       o_window;
  logic                o_valid;
  logic                o_frame_done;
  logic                o_busy;

  conv_window_gen #(
    .WIDTH (W),
    .IMG_W (IW),
    .IMG_H (IH),
    .K     (KK)
  ) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_window     (o_window),
    .o_valid      (o_valid),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mrow = 0, mcol = 0;
  logic [W-1:0]  pix_mem [NPIX];
  logic [WB-1:0] last_win = '0;
  bit            have_win = 1'b0;
  int            vcount = 0, dcount = 0;

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pixval(input int mode, input int i);
    if (mode == 0) return W'(i % 256);
    return W'((i * 7 + 3) % 256);
  endfunction

  // Window element (r,c) is the pixel at (row-(K-1-r), col-(K-1-c)).
  function automatic logic [WB-1:0] exp_win(input int row, input int col);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < KK; r++)
      for (int c = 0; c < KK; c++)
        w[(r*KK+c)*W +: W] = pix_mem[(row - (KK-1-r)) * IW + (col - (KK-1-c))];
    return w;
  endfunction

  task automatic step(input bit v, input logic [W-1:0] d, input bit clr);
    int idx;
    bit ev, ed;
    i_valid = v;
    i_data  = d;
    i_clear = clr;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    if (clr) begin
      mrow = 0;
      mcol = 0;
      have_win = 1'b0;
      check("clr_valid", WB'(o_valid), '0);
      check("clr_done", WB'(o_frame_done), '0);
      check("clr_busy", WB'(o_busy), '0);
      check("clr_window", o_window, '0);
    end else if (v) begin
      idx = mrow * IW + mcol;
      pix_mem[idx] = d;
      ev = (mrow >= KK-1) && (mcol >= KK-1);
      ed = (idx == NPIX-1);
      check("valid", WB'(o_valid), WB'(ev));
      check("done", WB'(o_frame_done), WB'(ed));
      if (ev) begin
        last_win = exp_win(mrow, mcol);
        have_win = 1'b1;
        check("window", o_window, last_win);
      end else begin
        have_win = 1'b0;
      end
      if (mcol == IW-1) begin
        mcol = 0;
        mrow = (mrow == IH-1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
      check("busy", WB'(o_busy), WB'((mrow != 0) || (mcol != 0)));
    end else begin
      check("gap_valid", WB'(o_valid), '0);
      check("gap_done", WB'(o_frame_done), '0);
      check("gap_busy", WB'(o_busy), WB'((mrow != 0) || (mcol != 0)));
      if (have_win) check("gap_hold", o_window, last_win);
    end
    if (o_valid) vcount++;
    if (o_frame_done) dcount++;
  endtask

  task automatic send_pixels(input int mode, input int first, input int count, input int gap_pct);
    for (int i = first; i < first + count; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) step(1'b0, W'($urandom), 1'b0);
      step(1'b1, pixval(mode, i), 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, WB'(o_valid), '0);
    check({tag, "_done"}, WB'(o_frame_done), '0);
    check({tag, "_busy"}, WB'(o_busy), '0);
    check({tag, "_window"}, o_window, '0);
  endtask

  initial begin
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);

    // Plain frame, index ramp.
    vcount = 0; dcount = 0;
    send_pixels(0, 0, NPIX, 0);
    check("f1_vcount", WB'(vcount), WB'(NWIN));
    check("f1_dcount", WB'(dcount), WB'(1));
    check("f1_last44", WB'(o_window[24*W +: W]), WB'(783 % 256));
    check("f1_last00", WB'(o_window[0 +: W]), WB'((783 - 4*IW - 4) % 256));

    // Same frame with frequent input gaps.
    vcount = 0; dcount = 0;
    send_pixels(0, 0, NPIX, 40);
    check("f2_vcount", WB'(vcount), WB'(NWIN));
    check("f2_dcount", WB'(dcount), WB'(1));

    // Two frames back to back, different content.
    vcount = 0; dcount = 0;
    send_pixels(1, 0, NPIX, 0);
    send_pixels(0, 0, NPIX, 0);
    check("b2b_vcount", WB'(vcount), WB'(2 * NWIN));
    check("b2b_dcount", WB'(dcount), WB'(2));

    // Asynchronous reset mid-frame.
    send_pixels(1, 0, 301, 0);
    #2;
    global_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    @(negedge clk);
    global_rst_n = 1'b1;
    mrow = 0; mcol = 0; have_win = 1'b0;
    vcount = 0; dcount = 0;
    send_pixels(1, 0, NPIX, 0);
    check("rst_vcount", WB'(vcount), WB'(NWIN));
    check("rst_dcount", WB'(dcount), WB'(1));

    // Clear collides with a valid pixel.
    send_pixels(0, 0, 500, 0);
    step(1'b1, pixval(0, 500), 1'b1);
    vcount = 0; dcount = 0;
    send_pixels(1, 0, NPIX, 10);
    check("clr_vcount", WB'(vcount), WB'(NWIN));
    check("clr_dcount", WB'(dcount), WB'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
